// File: rtl/ifq_pkg.sv
// Purpose: shared widths, reset PC, fetch entry type and FSM state codes for the fetch queue.
// Latency: none, definitions only.
// Backpressure: none, definitions only.
package ifq_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/ifq_fifo.sv
// Purpose: generic synchronous FIFO, DEPTH entries of W bits, head visible combinationally.
// Latency: push to visible-at-head is 1 cycle; clear empties the FIFO on the next edge.
// Backpressure: none internally; the caller must not push when full or pop when empty.
module ifq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    input  logic                     clear,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign count    = wr_ptr - rd_ptr;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (count == (AW+1)'(DEPTH));
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Pointers: clear wins over push/pop so a flush leaves nothing behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is data-only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/ifetch_queue.sv
// Purpose: fetch front end owning the PC; issues word reads, queues {pc, instr} for the core, flushes on redirect.
// Latency: rsp->out_valid 1 cycle (0 when IFQ_BYPASS_EN is defined); redirect->next mem request 1 cycle.
// Backpressure: requests held off while inflight+queued reaches DEPTH; out_ready low fills the queue, never drops data.
module ifetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [PC_W-1:0]    mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [1:0]        state, state_nxt;
    logic [PC_W-1:0]   fetch_pc, fetch_pc_nxt;
    logic [PC_W-1:0]   rsp_pc, rsp_pc_nxt;
    logic [CNT_W-1:0]  inflight, inflight_nxt;
    logic [CNT_W-1:0]  discard, discard_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occ;
    logic              fifo_empty, fifo_full;
    logic              req_acc, rsp_ok, rsp_keep, push, pop;
    fetch_entry_t      rsp_ent, head_ent, out_ent;

    // Credit: every outstanding request must have a guaranteed queue slot.
    assign occ           = {1'b0, inflight} + {1'b0, count};
    assign mem_req_valid = (state != ST_IDLE) && !redirect_valid && (occ < (CNT_W+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign req_acc       = mem_req_valid && mem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok   = mem_rsp_valid && (inflight != '0);
    assign rsp_keep = rsp_ok && (discard == '0) && !redirect_valid;
    assign rsp_ent  = '{pc: rsp_pc, instr: mem_rsp_data};
    assign pop      = !fifo_empty && out_ready && !redirect_valid;

`ifdef IFQ_BYPASS_EN
    logic byp;
    assign byp       = rsp_keep && fifo_empty;
    assign out_valid = !fifo_empty || byp;
    assign out_ent   = !fifo_empty ? head_ent : (byp ? rsp_ent : '0);
    assign push      = rsp_keep && !(byp && out_ready);
`else
    assign out_valid = !fifo_empty;
    assign out_ent   = fifo_empty ? '0 : head_ent;
    assign push      = rsp_keep;
`endif

    assign out_pc    = out_ent.pc;
    assign out_instr = out_ent.instr;

    ifq_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(fetch_entry_t))
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (rsp_ent),
        .pop      (pop),
        .clear    (redirect_valid),
        .head_dat (head_ent),
        .count    (count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // Counter updates; a redirect restarts both PCs and marks all outstanding requests stale.
    always_comb begin
        fetch_pc_nxt = fetch_pc + PC_W'(req_acc);
        rsp_pc_nxt   = rsp_pc + PC_W'(rsp_keep);
        inflight_nxt = inflight + CNT_W'(req_acc) - CNT_W'(rsp_ok);
        discard_nxt  = discard;
        if (rsp_ok && (discard != '0)) discard_nxt = discard - CNT_W'(1);
        if (redirect_valid) begin
            fetch_pc_nxt = redirect_pc;
            rsp_pc_nxt   = redirect_pc;
            discard_nxt  = inflight_nxt;
        end
    end

    // FSM: FLUSH lasts exactly while stale responses remain to be dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = (discard_nxt != '0) ? ST_FLUSH : ST_RUN;
            ST_RUN:   if (redirect_valid && (discard_nxt != '0)) state_nxt = ST_FLUSH;
            ST_FLUSH: if (discard_nxt == '0) state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            rsp_pc   <= rsp_pc_nxt;
            inflight <= inflight_nxt;
            discard  <= discard_nxt;
        end
    end

    a_rsp_has_credit: assert property (@(posedge clk) disable iff (!reset_n)
        mem_rsp_valid |-> (inflight != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;
    import ifq_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic               rv;
        logic [PC_W-1:0]    ra;
        logic               ov;
        logic [PC_W-1:0]    opc;
        logic [INSTR_W-1:0] oin;
    } snap_t;

    typedef struct packed {
        logic [PC_W-1:0] addr;
        logic            stale;
    } pend_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [PC_W-1:0]    mem_req_addr;
    logic               mem_rsp_valid;
    logic [INSTR_W-1:0] mem_rsp_data;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;

    ifetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding memory requests, number of kept-but-unconsumed
    // instructions, and the next expected request / output PC.
    pend_t           pend[$];
    int              held;
    logic [PC_W-1:0] exp_req_pc;
    logic [PC_W-1:0] exp_out_pc;
    bit              started;
    snap_t           exp_s, obs_s;
    int              n_tests = 0;
    int              n_fail  = 0;

    function automatic logic [INSTR_W-1:0] memf(input logic [PC_W-1:0] a);
        return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        out_ready      = 1'b0;
        pend.delete();
        held       = 0;
        exp_req_pc = RESET_PC;
        exp_out_pc = RESET_PC;
        started    = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One cycle: drive inputs at the negedge, sample just after, advance the model.
    task automatic step(input bit redir, input logic [PC_W-1:0] rpc,
                        input bit ordy, input bit mrdy, input bit rsp_en);
        pend_t e;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = ordy;
        mem_req_ready  = mrdy;
        mem_rsp_valid  = rsp_en && (pend.size() > 0);
        mem_rsp_data   = mem_rsp_valid ? memf(pend[0].addr) : INSTR_W'($urandom);
        #1;
        exp_s.rv  = started && !redir && ((pend.size() + held) < DEPTH);
        exp_s.ra  = exp_s.rv ? exp_req_pc : '0;
        exp_s.ov  = (held > 0);
        exp_s.opc = exp_s.ov ? exp_out_pc : '0;
        exp_s.oin = exp_s.ov ? memf(exp_out_pc) : '0;
        obs_s.rv  = mem_req_valid;
        obs_s.ra  = mem_req_valid ? mem_req_addr : '0;
        obs_s.ov  = out_valid;
        obs_s.opc = out_valid ? out_pc : '0;
        obs_s.oin = out_valid ? out_instr : '0;
        if (mem_rsp_valid) begin
            e = pend.pop_front();
            if (!e.stale && !redir) held++;
        end
        if (exp_s.ov && ordy && !redir) begin
            held--;
            exp_out_pc++;
        end
        if (exp_s.rv && mrdy) begin
            pend.push_back('{addr: exp_req_pc, stale: 1'b0});
            exp_req_pc++;
        end
        if (redir) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            held       = 0;
            exp_req_pc = rpc;
            exp_out_pc = rpc;
        end
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; out_ready = 1'b1;
        #1;
        n_tests++;
        if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valids req_vld=%b out_vld=%b want 0 0", mem_req_valid, out_valid);
        end
        n_tests++;
        if (mem_req_addr !== RESET_PC || out_pc !== '0 || out_instr !== '0) begin
            n_fail++;
            $display("FAIL reset_data addr=%h pc=%h instr=%h want %h 0 0", mem_req_addr, out_pc, out_instr, RESET_PC);
        end
        do_reset();
        step(0, '0, 1, 1, 1);
        n_tests++;
        if (obs_s.rv !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_cycle req_vld=%b want 0", obs_s.rv);
        end
    endtask

    task automatic test_stream();
        int n_out = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            step(0, '0, 1, 1, 1);
            n_tests++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL stream c%0d got=%h want=%h", c, obs_s, exp_s);
            end
            if (c >= 10 && obs_s.ov) n_out++;
        end
        n_tests++;
        if (n_out !== 30) begin
            n_fail++;
            $display("FAIL stream_throughput got=%0d want=30", n_out);
        end
    endtask

    task automatic test_backpressure();
        int n_acc = 0;
        logic [PC_W-1:0] got[$];
        do_reset();
        for (int c = 0; c < 14; c++) begin
            step(0, '0, 0, 1, 1);
            n_tests++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL bp_fill c%0d got=%h want=%h", c, obs_s, exp_s);
            end
            if (obs_s.rv) n_acc++;
        end
        n_tests++;
        if (n_acc !== DEPTH || obs_s.rv !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_credit accepted=%0d last_vld=%b want %0d 0", n_acc, obs_s.rv, DEPTH);
        end
        for (int c = 0; c < 10; c++) begin
            step(0, '0, 1, 0, 1);
            n_tests++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL bp_drain c%0d got=%h want=%h", c, obs_s, exp_s);
            end
            if (obs_s.ov) got.push_back(obs_s.opc);
        end
        n_tests++;
        if (got.size() !== 4) begin
            n_fail++;
            $display("FAIL bp_drain_count got=%0d want=4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (got[i] !== PC_W'(i)) begin
                    n_fail++;
                    $display("FAIL bp_order idx%0d got=%h want=%h", i, got[i], PC_W'(i));
                end
            end
        end
    endtask

    task automatic test_redirect_inflight();
        bit first_req = 1'b1;
        bit first_out = 1'b1;
        do_reset();
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        step(1, 64'h40, 1, 1, 0);
        n_tests++;
        if (obs_s.rv !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_no_req got=%b want=0", obs_s.rv);
        end
        for (int c = 0; c < 12; c++) begin
            step(0, '0, 1, 1, 1);
            n_tests++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL redir c%0d got=%h want=%h", c, obs_s, exp_s);
            end
            if (c == 0) begin
                n_tests++;
                if (obs_s.rv !== 1'b1) begin
                    n_fail++;
                    $display("FAIL redir_latency req_vld=%b want=1", obs_s.rv);
                end
            end
            if (obs_s.rv && first_req) begin
                first_req = 1'b0;
                n_tests++;
                if (obs_s.ra !== 64'h40) begin
                    n_fail++;
                    $display("FAIL redir_first_addr got=%h want=40", obs_s.ra);
                end
            end
            if (obs_s.ov && first_out) begin
                first_out = 1'b0;
                n_tests++;
                if (obs_s.opc !== 64'h40 || obs_s.oin !== memf(64'h40)) begin
                    n_fail++;
                    $display("FAIL redir_first_out pc=%h instr=%h want 40 %h", obs_s.opc, obs_s.oin, memf(64'h40));
                end
            end
        end
        if (first_out) begin
            n_tests++; n_fail++;
            $display("FAIL redir_timeout no output after redirect");
        end
    endtask

    task automatic test_redirect_coincident();
        bit first_out = 1'b1;
        do_reset();
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 1);
        step(0, '0, 0, 1, 0);
        step(1, 64'h100, 1, 0, 1);
        n_tests++;
        if (obs_s.ov !== 1'b1 || obs_s.opc !== 64'd0 || obs_s.rv !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_cycle out_vld=%b pc=%h req_vld=%b want 1 0 0", obs_s.ov, obs_s.opc, obs_s.rv);
        end
        step(0, '0, 1, 1, 0);
        n_tests++;
        if (obs_s.ov !== 1'b0 || obs_s.rv !== 1'b1 || obs_s.ra !== 64'h100) begin
            n_fail++;
            $display("FAIL coinc_after out_vld=%b req_vld=%b addr=%h want 0 1 100", obs_s.ov, obs_s.rv, obs_s.ra);
        end
        for (int c = 0; c < 12; c++) begin
            step(0, '0, 1, 1, 1);
            n_tests++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL coinc c%0d got=%h want=%h", c, obs_s, exp_s);
            end
            if (obs_s.ov && first_out) begin
                first_out = 1'b0;
                n_tests++;
                if (obs_s.opc !== 64'h100 || obs_s.oin !== memf(64'h100)) begin
                    n_fail++;
                    $display("FAIL coinc_first_out pc=%h instr=%h want 100 %h", obs_s.opc, obs_s.oin, memf(64'h100));
                end
            end
        end
        if (first_out) begin
            n_tests++; n_fail++;
            $display("FAIL coinc_timeout no output after redirect");
        end
    endtask

    task automatic test_pc_wrap();
        logic [PC_W-1:0] ones = '1;
        logic [PC_W-1:0] reqs[$];
        logic [PC_W-1:0] outs[$];
        do_reset();
        step(0, '0, 0, 0, 0);
        step(1, ones, 1, 1, 1);
        for (int c = 0; c < 10; c++) begin
            step(0, '0, 1, 1, 1);
            n_tests++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL wrap c%0d got=%h want=%h", c, obs_s, exp_s);
            end
            if (obs_s.rv) reqs.push_back(obs_s.ra);
            if (obs_s.ov) outs.push_back(obs_s.opc);
        end
        n_tests++;
        if (reqs.size() < 2 || reqs[0] !== ones || reqs[1] !== '0) begin
            n_fail++;
            $display("FAIL wrap_addr n=%0d first=%h want ffffffffffffffff then 0", reqs.size(), reqs.size() > 0 ? reqs[0] : '0);
        end
        n_tests++;
        if (outs.size() < 2 || outs[0] !== ones || outs[1] !== '0) begin
            n_fail++;
            $display("FAIL wrap_pc n=%0d first=%h want ffffffffffffffff then 0", outs.size(), outs.size() > 0 ? outs[0] : '0);
        end
    endtask

    task automatic test_reset_midstream();
        bit first_req = 1'b1;
        bit first_out = 1'b1;
        do_reset();
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 1);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        n_tests++;
        if (obs_s !== exp_s) begin
            n_fail++;
            $display("FAIL rstmid_pre got=%h want=%h", obs_s, exp_s);
        end
        #3 reset_n = 1'b0;
        #1;
        n_tests++;
        if (mem_req_valid !== 1'b0 || out_valid !== 1'b0 || mem_req_addr !== RESET_PC ||
            out_pc !== '0 || out_instr !== '0) begin
            n_fail++;
            $display("FAIL rstmid_async req_vld=%b out_vld=%b addr=%h pc=%h instr=%h want 0 0 %h 0 0",
                     mem_req_valid, out_valid, mem_req_addr, out_pc, out_instr, RESET_PC);
        end
        @(negedge clk);
        repeat (3) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = INSTR_W'($urandom);
            @(negedge clk);
        end
        do_reset();
        for (int c = 0; c < 10; c++) begin
            step(0, '0, 1, 1, 1);
            n_tests++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL rstmid c%0d got=%h want=%h", c, obs_s, exp_s);
            end
            if (obs_s.rv && first_req) begin
                first_req = 1'b0;
                n_tests++;
                if (obs_s.ra !== RESET_PC) begin
                    n_fail++;
                    $display("FAIL rstmid_restart addr=%h want=%h", obs_s.ra, RESET_PC);
                end
            end
            if (obs_s.ov && first_out) begin
                first_out = 1'b0;
                n_tests++;
                if (obs_s.opc !== RESET_PC || obs_s.oin !== memf(RESET_PC)) begin
                    n_fail++;
                    $display("FAIL rstmid_first_out pc=%h instr=%h want %h %h", obs_s.opc, obs_s.oin, RESET_PC, memf(RESET_PC));
                end
            end
        end
        if (first_out) begin
            n_tests++; n_fail++;
            $display("FAIL rstmid_timeout no output after reset");
        end
    endtask

    task automatic test_random();
        bit              redir;
        logic [PC_W-1:0] rpc;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            redir = ($urandom_range(0, 19) == 0);
            rpc   = {$urandom, $urandom};
            step(redir, rpc, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            n_tests++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL random c%0d got=%h want=%h", c, obs_s, exp_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_pc_wrap();
        test_reset_midstream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
